viterbi_trellis_engine: RTL and testbench

//  Parametrised Viterbi decoder for HMM POS tagging: N_POS states, up to MAX_WORDS words.

---
 rtl/viterbi_pkg.sv | 38 +++
 rtl/viterbi_trellis_engine_bp_ram.sv | 26 ++
 rtl/viterbi_trellis_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_viterbi_trellis_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types, score limits and saturating arithmetic for the Viterbi trellis engine.
package viterbi_pkg;

    localparam int P_SIZE = 32;

    typedef logic signed [P_SIZE-1:0] t_score;

    localparam t_score SCORE_MAX = {1'b0, {(P_SIZE-1){1'b1}}};
    localparam t_score SCORE_MIN = {1'b1, {(P_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACS,
        S_SWAP,
        S_FINAL,
        S_BACK,
        S_EMIT
    } t_vit_state;

    // One guard bit catches the overflow; its disagreement with the MSB picks the clamp side.
    function automatic t_score sat_add(input t_score a, input t_score b);
        logic [P_SIZE:0] s;
        s = {a[P_SIZE-1], a} + {b[P_SIZE-1], b};
        if (s[P_SIZE] != s[P_SIZE-1])
            return s[P_SIZE] ? SCORE_MIN : SCORE_MAX;
        return t_score'(s[P_SIZE-1:0]);
    endfunction

    function automatic t_score sat_sub(input t_score a, input t_score b);
        logic [P_SIZE:0] s;
        s = {a[P_SIZE-1], a} - {b[P_SIZE-1], b};
        if (s[P_SIZE] != s[P_SIZE-1])
            return s[P_SIZE] ? SCORE_MIN : SCORE_MAX;
        return t_score'(s[P_SIZE-1:0]);
    endfunction

endpackage

// File: rtl/viterbi_trellis_engine_bp_ram.sv
// Backpointer store: one write port, registered read (data valid the cycle after the address).
module viterbi_bp_ram #(
    parameter int DEPTH = 176,
    parameter int AW    = 8,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/viterbi_trellis_engine.sv
// Serial log-domain Viterbi decoder with backtrace and valid/ready path output.
// Define VITERBI_NORM_EN to renormalise each score column to a maximum of 0 during SWAP.
module viterbi_trellis_engine
    import viterbi_pkg::*;
#(
    parameter int N_POS     = 11,
    parameter int POS_BITS  = 4,
    parameter int P_SIZE    = 32,
    parameter int MAX_WORDS = 16,
    parameter int WORD_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_BITS:0]   n_words,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WORD_BITS-1:0] word_idx,
    output logic [POS_BITS-1:0]  cur_pos,
    output logic [POS_BITS-1:0]  prev_pos,
    input  logic [P_SIZE-1:0]    init_data,
    input  logic [P_SIZE-1:0]    emiss_data,
    input  logic [P_SIZE-1:0]    trans_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [POS_BITS-1:0]  out_pos,
    output logic [WORD_BITS-1:0] out_idx,
    output logic                 out_last
);

    localparam int BP_DEPTH = MAX_WORDS * N_POS;
    localparam int BP_AW    = $clog2(BP_DEPTH);

    typedef logic [POS_BITS-1:0]  t_pos;
    typedef logic [WORD_BITS-1:0] t_word;

    localparam t_pos LAST_POS = t_pos'(N_POS - 1);

    t_vit_state state_q, state_d;
    t_pos       c_q, c_d, p_q, p_d, arg_q, arg_d;
    t_word      t_q, t_d, nm1_q, nm1_d;
    t_score     best_q, best_d;
    t_score     score_q [N_POS];
    t_score     score_d [N_POS];
    t_score     new_q   [N_POS];
    t_score     new_d   [N_POS];
    t_pos       path_q  [MAX_WORDS];
    t_pos       path_d  [MAX_WORDS];
    logic       done_q, done_d, error_q, error_d;
`ifdef VITERBI_NORM_EN
    logic       sub_q, sub_d;
`endif

    t_score     cand, acs_best;
    t_pos       acs_arg, back_pos;
    logic       take, fin_take, swap_done;
    logic             bp_we;
    logic [BP_AW-1:0] bp_waddr, bp_raddr;
    t_pos             bp_wdata, bp_rdata;

    viterbi_bp_ram #(
        .DEPTH (BP_DEPTH),
        .AW    (BP_AW),
        .DW    (POS_BITS)
    ) u_bp_ram (
        .clk   (clk),
        .we    (bp_we),
        .waddr (bp_waddr),
        .wdata (bp_wdata),
        .raddr (bp_raddr),
        .rdata (bp_rdata)
    );

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        p_d       = p_q;
        t_d       = t_q;
        nm1_d     = nm1_q;
        best_d    = best_q;
        arg_d     = arg_q;
        score_d   = score_q;
        new_d     = new_q;
        path_d    = path_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
`ifdef VITERBI_NORM_EN
        sub_d     = sub_q;
`endif
        swap_done = 1'b0;
        back_pos  = '0;
        bp_we     = 1'b0;
        bp_waddr  = '0;
        bp_wdata  = '0;
        bp_raddr  = '0;
        word_idx  = '0;
        cur_pos   = '0;
        prev_pos  = '0;
        out_valid = 1'b0;
        out_pos   = '0;
        out_idx   = '0;
        out_last  = 1'b0;

        // The first predecessor always seeds the running best; later ones must be strictly better.
        cand     = sat_add(score_q[p_q], trans_data);
        take     = (p_q == '0) || (cand > best_q);
        acs_best = take ? cand : best_q;
        acs_arg  = take ? p_q : arg_q;
        fin_take = (c_q == '0) || (score_q[c_q] > best_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_words == '0 || n_words > (WORD_BITS+1)'(MAX_WORDS)) begin
                        error_d = 1'b1;
                    end else begin
                        nm1_d   = t_word'(n_words - 1'b1);
                        c_d     = '0;
                        p_d     = '0;
                        t_d     = '0;
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                cur_pos         = c_q;
                score_d[c_q]    = sat_add(init_data, emiss_data);
                if (c_q == LAST_POS) begin
                    c_d     = '0;
                    t_d     = t_word'(1);
                    state_d = (nm1_q == '0) ? S_FINAL : S_ACS;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_ACS: begin
                word_idx = t_q;
                cur_pos  = c_q;
                prev_pos = p_q;
                best_d   = acs_best;
                arg_d    = acs_arg;
                if (p_q == LAST_POS) begin
                    new_d[c_q] = sat_add(acs_best, emiss_data);
                    bp_we      = 1'b1;
                    bp_waddr   = BP_AW'(int'(t_q) * N_POS + int'(c_q));
                    bp_wdata   = acs_arg;
                    p_d        = '0;
                    if (c_q == LAST_POS) begin
                        c_d     = '0;
                        state_d = S_SWAP;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            S_SWAP: begin
`ifdef VITERBI_NORM_EN
                // Scan for the column maximum, then subtract it everywhere in one cycle.
                if (!sub_q) begin
                    if (c_q == '0 || new_q[c_q] > best_q)
                        best_d = new_q[c_q];
                    if (c_q == LAST_POS) begin
                        c_d   = '0;
                        sub_d = 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    for (int i = 0; i < N_POS; i++)
                        score_d[i] = sat_sub(new_q[i], best_q);
                    sub_d     = 1'b0;
                    swap_done = 1'b1;
                end
`else
                score_d   = new_q;
                swap_done = 1'b1;
`endif
                if (swap_done) begin
                    if (t_q == nm1_q) begin
                        c_d     = '0;
                        state_d = S_FINAL;
                    end else begin
                        t_d     = t_q + 1'b1;
                        state_d = S_ACS;
                    end
                end
            end
            S_FINAL: begin
                if (fin_take) begin
                    best_d = score_q[c_q];
                    arg_d  = c_q;
                end
                if (c_q == LAST_POS) begin
                    c_d     = '0;
                    t_d     = nm1_q;
                    state_d = S_BACK;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_BACK: begin
                // Each cycle consumes the previous cycle's RAM read and launches the next one.
                back_pos     = (t_q == nm1_q) ? arg_q : bp_rdata;
                path_d[t_q]  = back_pos;
                bp_raddr     = BP_AW'(int'(t_q) * N_POS + int'(back_pos));
                if (t_q == '0)
                    state_d = S_EMIT;
                else
                    t_d = t_q - 1'b1;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_pos   = path_q[t_q];
                out_idx   = t_q;
                out_last  = (t_q == nm1_q);
                if (out_ready) begin
                    if (t_q == nm1_q) begin
                        done_d  = 1'b1;
                        t_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            p_q     <= '0;
            t_q     <= '0;
            nm1_q   <= '0;
            best_q  <= '0;
            arg_q   <= '0;
            score_q <= '{default: '0};
            new_q   <= '{default: '0};
            path_q  <= '{default: '0};
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef VITERBI_NORM_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            p_q     <= p_d;
            t_q     <= t_d;
            nm1_q   <= nm1_d;
            best_q  <= best_d;
            arg_q   <= arg_d;
            score_q <= score_d;
            new_q   <= new_d;
            path_q  <= path_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef VITERBI_NORM_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_viterbi_trellis_engine.sv
// Self-checking bench: directed vector table, corner sequences and randomized tables vs a DP model.
module tb_viterbi_trellis_engine;

    localparam int N  = 2;
    localparam int MW = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [2:0]  n_words;
    logic        busy, done, error, out_valid, out_last;
    logic [1:0]  word_idx, out_idx;
    logic [0:0]  cur_pos, prev_pos, out_pos;
    logic [31:0] init_data, emiss_data, trans_data;

    int init_tab  [N];
    int trans_tab [N][N];
    int emiss_tab [MW][N];
    int exp_path  [MW];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign init_data  = init_tab[cur_pos];
    assign emiss_data = emiss_tab[word_idx][cur_pos];
    assign trans_data = trans_tab[prev_pos][cur_pos];

    viterbi_trellis_engine #(
        .N_POS(N), .POS_BITS(1), .P_SIZE(32), .MAX_WORDS(MW), .WORD_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .n_words(n_words),
        .busy(busy), .done(done), .error(error),
        .word_idx(word_idx), .cur_pos(cur_pos), .prev_pos(prev_pos),
        .init_data(init_data), .emiss_data(emiss_data), .trans_data(trans_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .out_idx(out_idx), .out_last(out_last)
    );

    task automatic chk(input string nm, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Textbook Viterbi over the tables: best-predecessor DP, then backtrack.
    task automatic model(input int n);
        longint s [N];
        longint ns [N];
        int bp [MW][N];
        longint best, v;
        int arg;
        for (int c = 0; c < N; c++)
            s[c] = clamp(longint'(init_tab[c]) + longint'(emiss_tab[0][c]));
        for (int t = 1; t < n; t++) begin
            for (int c = 0; c < N; c++) begin
                best = SMIN; arg = -1;
                for (int p = 0; p < N; p++) begin
                    v = clamp(s[p] + longint'(trans_tab[p][c]));
                    if (arg < 0 || v > best) begin best = v; arg = p; end
                end
                ns[c] = clamp(best + longint'(emiss_tab[t][c]));
                bp[t][c] = arg;
            end
            s = ns;
        end
        arg = 0;
        for (int c = 1; c < N; c++)
            if (s[c] > s[arg]) arg = c;
        exp_path[n-1] = arg;
        for (int t = n - 1; t > 0; t--)
            exp_path[t-1] = bp[t][exp_path[t]];
    endtask

    task automatic set_default_tables();
        init_tab[0] = 0; init_tab[1] = -10;
        for (int p = 0; p < N; p++)
            for (int c = 0; c < N; c++)
                trans_tab[p][c] = (p == c) ? 0 : -5;
        for (int w = 0; w < MW; w++)
            for (int c = 0; c < N; c++)
                emiss_tab[w][c] = 0;
    endtask

    // Start a decode, check latency, collect the path against exp_path and check the done pulse.
    task automatic decode(input string nm, input int n, input int stall_at, input int stall_len);
        int cyc, k, guard, stalled, lat;
        n_words = 3'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = 1 + N + (n - 1) * (N * N + 1) + N + n;
`ifdef VITERBI_NORM_EN
        lat += (n - 1) * N;
`endif
        chk({nm, " latency"}, cyc, lat);
        k = 0; guard = 0; stalled = 0;
        while (k < n && guard < 100) begin
            if (out_valid) begin
                if (k == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    chk({nm, " held idx"}, out_idx, k);
                    chk({nm, " held pos"}, out_pos, exp_path[k]);
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    chk({nm, " pos"}, out_pos, exp_path[k]);
                    chk({nm, " idx"}, out_idx, k);
                    chk({nm, " last"}, out_last, (k == n - 1) ? 1 : 0);
                    k++;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        chk({nm, " elements"}, k, n);
        chk({nm, " done"}, done, 1);
        chk({nm, " busy after"}, busy, 0);
        @(posedge clk); #1;
        chk({nm, " done pulse"}, done, 0);
    endtask

    typedef struct {
        string nm;
        int    n;
        int    e_word;
        int    e_pos;
        int    e_val;
        int    expv [MW];
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{"all_zero",  3, 0, 0,    0, '{0, 0, 0, 0}};
        vecs[1] = '{"tie_bp",    3, 2, 0, -100, '{0, 0, 1, 0}};
        vecs[2] = '{"one_word",  1, 0, 1,   20, '{1, 0, 0, 0}};
        vecs[3] = '{"max_words", 4, 1, 1,   30, '{0, 1, 1, 1}};

        reset = 1'b0; start = 1'b0; n_words = '0; out_ready = 1'b1;
        set_default_tables();
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst addr", {word_idx, cur_pos, prev_pos, out_pos, out_idx}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            set_default_tables();
            emiss_tab[vecs[i].e_word][vecs[i].e_pos] = vecs[i].e_val;
            for (int k = 0; k < MW; k++) exp_path[k] = vecs[i].expv[k];
            decode(vecs[i].nm, vecs[i].n, -1, 0);
        end

        // Illegal lengths are rejected with a single error pulse.
        for (int r = 0; r < 2; r++) begin
            n_words = (r == 0) ? 3'd0 : 3'd5;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("reject error", error, 1);
            chk("reject busy", busy, 0);
            chk("reject valid", out_valid, 0);
            @(posedge clk); #1;
            chk("reject pulse", error, 0);
            chk("reject idle", busy, 0);
        end

        // Backpressure at idx 1 for 5 cycles.
        set_default_tables();
        exp_path = '{0, 0, 0, 0};
        decode("stall", 3, 1, 5);

        // Mid-ACS reset, with a start issued while busy that must be ignored.
        set_default_tables();
        emiss_tab[2][0] = -100;
        n_words = 3'd3;
        start = 1'b1;
        @(posedge clk); #1;
        n_words = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy start ignored", error, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort busy", busy, 0);
        chk("abort valid", out_valid, 0);
        reset = 1'b1;
        exp_path = '{0, 0, 1, 0};
        decode("restart", 3, -1, 0);

        // Scores pinned near the negative limit must clamp, not wrap.
        set_default_tables();
        init_tab[0] = -(1 << 30); init_tab[1] = -(1 << 30);
        for (int p = 0; p < N; p++)
            for (int c = 0; c < N; c++)
                trans_tab[p][c] = -(1 << 30);
        exp_path = '{0, 0, 0, 0};
        decode("saturate", 4, -1, 0);

        for (int it = 0; it < 20; it++) begin
            int n;
            for (int c = 0; c < N; c++) init_tab[c] = int'($urandom_range(0, 127)) - 64;
            for (int p = 0; p < N; p++)
                for (int c = 0; c < N; c++)
                    trans_tab[p][c] = int'($urandom_range(0, 127)) - 64;
            for (int w = 0; w < MW; w++)
                for (int c = 0; c < N; c++)
                    emiss_tab[w][c] = int'($urandom_range(0, 127)) - 64;
            n = int'($urandom_range(1, MW));
            model(n);
            decode("random", n, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
